// File: rtl/alu_decoder_pkg.sv
// Shared RV32I opcode header: ALU op encoding plus the opcode and funct7
// constants used by both the decode stage and the ALU.
package alu_decoder_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/alu_decode_comb.sv
// Purely combinational RV32I integer decode; illegal encodings collapse to
// a flagged NOP so the ALU never sees anything outside alu_op_e.
module alu_decode_comb
  import alu_decoder_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  op,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic        use_imm,
  output logic        illegal
);

  alu_op_e     op_e;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign op     = op_e;

  always_comb begin
    op_e    = ALU_ADD;
    rs1     = instr[19:15];
    rs2     = instr[24:20];
    rd      = instr[11:7];
    imm     = 32'd0;
    use_imm = 1'b0;
    illegal = 1'b0;

    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000: op_e = ALU_ADD;
            3'b001: op_e = ALU_SLL;
            3'b010: op_e = ALU_SLT;
            3'b011: op_e = ALU_SLTU;
            3'b100: op_e = ALU_XOR;
            3'b101: op_e = ALU_SRL;
            3'b110: op_e = ALU_OR;
            default: op_e = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          op_e = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          op_e = ALU_SRA;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        use_imm = 1'b1;
        rs2     = 5'd0;
        imm     = {{20{instr[31]}}, instr[31:20]};
        case (funct3)
          3'b000: op_e = ALU_ADD;
          3'b010: op_e = ALU_SLT;
          3'b011: op_e = ALU_SLTU;
          3'b100: op_e = ALU_XOR;
          3'b110: op_e = ALU_OR;
          3'b111: op_e = ALU_AND;
          3'b001: begin
            imm     = {27'd0, instr[24:20]};
            op_e    = ALU_SLL;
            illegal = (funct7 != F7_BASE);
          end
          default: begin
            // funct7 bit 30 selects arithmetic vs logical right shift
            imm = {27'd0, instr[24:20]};
            if (funct7 == F7_BASE)     op_e = ALU_SRL;
            else if (funct7 == F7_ALT) op_e = ALU_SRA;
            else                       illegal = 1'b1;
          end
        endcase
      end
      OPC_LUI: begin
        rs1     = 5'd0;
        rs2     = 5'd0;
        use_imm = 1'b1;
        imm     = {instr[31:12], 12'd0};
      end
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      op_e    = ALU_ADD;
      rs1     = 5'd0;
      rs2     = 5'd0;
      rd      = 5'd0;
      imm     = 32'd0;
      use_imm = 1'b0;
    end
  end

endmodule

// File: rtl/alu_decoder.sv
// Decode stage in front of the ALU: one-entry registered payload with
// valid/ready backpressure and a saturating illegal-instruction counter.
module alu_decoder
  import alu_decoder_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_instr,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [3:0]       o_op,
  output logic [4:0]       o_rs1,
  output logic [4:0]       o_rs2,
  output logic [4:0]       o_rd,
  output logic [31:0]      o_imm,
  output logic             o_use_imm,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_illegal_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [3:0]       dec_op;
  logic [4:0]       dec_rs1, dec_rs2, dec_rd;
  logic [31:0]      dec_imm;
  logic             dec_use_imm, dec_illegal;
  logic             accept;

  logic             valid_reg;
  logic [3:0]       op_reg;
  logic [4:0]       rs1_reg, rs2_reg, rd_reg;
  logic [31:0]      imm_reg;
  logic             use_imm_reg, illegal_reg;
  logic [CNT_W-1:0] cnt_reg;

  alu_decode_comb u_decode (
    .instr   (i_instr),
    .op      (dec_op),
    .rs1     (dec_rs1),
    .rs2     (dec_rs2),
    .rd      (dec_rd),
    .imm     (dec_imm),
    .use_imm (dec_use_imm),
    .illegal (dec_illegal)
  );

  // Ready depends only on the output register state, never on the instruction.
  assign o_ready = !valid_reg || i_ready;
  assign accept  = i_valid && o_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_reg   <= 1'b0;
      op_reg      <= ALU_ADD;
      rs1_reg     <= 5'd0;
      rs2_reg     <= 5'd0;
      rd_reg      <= 5'd0;
      imm_reg     <= 32'd0;
      use_imm_reg <= 1'b0;
      illegal_reg <= 1'b0;
      cnt_reg     <= '0;
    end else if (accept) begin
      valid_reg   <= 1'b1;
      op_reg      <= dec_op;
      rs1_reg     <= dec_rs1;
      rs2_reg     <= dec_rs2;
      rd_reg      <= dec_rd;
      imm_reg     <= dec_imm;
      use_imm_reg <= dec_use_imm;
      illegal_reg <= dec_illegal;
      if (dec_illegal && cnt_reg != CNT_MAX) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end else if (i_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign o_valid       = valid_reg;
  assign o_op          = op_reg;
  assign o_rs1         = rs1_reg;
  assign o_rs2         = rs2_reg;
  assign o_rd          = rd_reg;
  assign o_imm         = imm_reg;
  assign o_use_imm     = use_imm_reg;
  assign o_illegal     = illegal_reg;
  assign o_illegal_cnt = cnt_reg;

endmodule

// File: tb/tb_alu_decoder.sv
// Scoreboard bench for alu_decoder: driver pushes reference-model results,
// a negedge monitor pops and compares on every output transfer.
module tb_alu_decoder;

  localparam int CNT_W = 8;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_valid = 1'b0;
  logic             i_ready = 1'b0;
  logic [31:0]      i_instr = 32'd0;
  logic             o_ready, o_valid, o_use_imm, o_illegal;
  logic [3:0]       o_op;
  logic [4:0]       o_rs1, o_rs2, o_rd;
  logic [31:0]      o_imm;
  logic [CNT_W-1:0] o_illegal_cnt;

  alu_decoder #(.CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_instr(i_instr), .o_valid(o_valid), .i_ready(i_ready), .o_op(o_op),
    .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd), .o_imm(o_imm),
    .o_use_imm(o_use_imm), .o_illegal(o_illegal), .o_illegal_cnt(o_illegal_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [3:0]       op;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [31:0]      imm;
    logic             use_imm;
    logic             illegal;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_pop_cyc = -1;
  int   model_cnt = 0;
  bit   rand_ready = 1'b0;
  int   ntx = 0;

  // Mnemonic order of OP funct3 with funct7=0: ADD SLL SLT SLTU XOR SRL OR AND
  int base_ops[8] = '{0, 2, 3, 4, 5, 6, 8, 9};

  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t e;
    bit ok;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    e = '0;
    ok = 1'b0;
    opc = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
    if (opc == 7'h33) begin
      e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
      if (f7 == 7'h00) begin e.op = 4'(base_ops[f3]); ok = 1'b1; end
      else if (f7 == 7'h20 && f3 == 3'd0) begin e.op = 4'd1; ok = 1'b1; end
      else if (f7 == 7'h20 && f3 == 3'd5) begin e.op = 4'd7; ok = 1'b1; end
    end else if (opc == 7'h13) begin
      e.rs1 = w[19:15]; e.rd = w[11:7]; e.use_imm = 1'b1;
      if (f3 == 3'd1) begin
        e.op = 4'd2; e.imm = 32'(w[24:20]); ok = (f7 == 7'h00);
      end else if (f3 == 3'd5) begin
        e.imm = 32'(w[24:20]);
        if (f7 == 7'h00) begin e.op = 4'd6; ok = 1'b1; end
        else if (f7 == 7'h20) begin e.op = 4'd7; ok = 1'b1; end
      end else begin
        e.op = 4'(base_ops[f3]);
        e.imm = 32'($signed(w[31:20]));
        ok = 1'b1;
      end
    end else if (opc == 7'h37) begin
      e.rd = w[11:7]; e.use_imm = 1'b1; e.imm = {w[31:12], 12'h000}; ok = 1'b1;
    end
    if (!ok) begin
      e = '0;
      e.illegal = 1'b1;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  exp_t cur;
  assign cur = {o_op, o_rs1, o_rs2, o_rd, o_imm, o_use_imm, o_illegal, o_illegal_cnt};

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(posedge i_clk) begin
    if (rand_ready) begin
      #1 i_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: a transfer happens on the next edge whenever o_valid && i_ready now.
  exp_t snap;
  bit   stalled = 1'b0;
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      stalled = 1'b0;
    end else begin
      check("o_ready", 64'(o_ready), 64'(!o_valid || i_ready));
      if (stalled && o_valid) check("stall_hold", 64'(cur), 64'(snap));
      if (o_valid && i_ready) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got %h expected none", cur);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("payload", 64'(cur), 64'(e));
          ntx++;
          $display("tx %0d: op=%0d rs1=%0d rs2=%0d rd=%0d imm=%h ui=%0b ill=%0b cnt=%0d",
                   ntx, o_op, o_rs1, o_rs2, o_rd, o_imm, o_use_imm, o_illegal, o_illegal_cnt);
        end
        last_pop_cyc = cyc + 1;
      end
      stalled = o_valid && !i_ready;
      snap = cur;
    end
  end

  task automatic send(input logic [31:0] w, output int acc);
    bit done;
    done = 1'b0;
    acc = -1;
    i_valid = 1'b1;
    i_instr = w;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge i_clk);
      if (o_ready) begin
        exp_t e;
        e = ref_decode(w);
        if (e.illegal && model_cnt < CNT_SAT) model_cnt++;
        e.cnt = CNT_W'(model_cnt);
        sb_q.push_back(e);
        acc = cyc + 1;
        done = 1'b1;
      end
      @(posedge i_clk); #1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no accept expected accept of %h", w);
    end
    i_valid = 1'b0;
  endtask

  task automatic drain_wait();
    for (int k = 0; k < 300 && sb_q.size() > 0; k++) @(posedge i_clk);
    if (sb_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
    end
    @(posedge i_clk); #1;
  endtask

  initial begin
    int a1, a2, acc;
    logic [31:0] r, w;
    logic [6:0] opc, f7;

    repeat (3) @(posedge i_clk);
    #1;
    check("reset_valid", 64'(o_valid), 64'd0);
    check("reset_payload", 64'(cur), 64'd0);
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    @(posedge i_clk); #1;

    // add then sub back to back
    send(32'h002081B3, a1);
    send(32'h402081B3, a2);
    check("back_to_back", 64'(a2), 64'(a1 + 1));
    send(32'hFFF00293, acc);
    send(32'h4033D313, acc);
    send({7'b0100001, 5'd3, 5'd7, 3'b101, 5'd6, 7'b0010011}, acc);
    send(32'h123450B7, acc);
    send(32'h00000000, acc);
    send(32'hFFFFFFFF, acc);
    drain_wait();

    // backpressure: A stalls 3 cycles, B loads on the edge A drains
    i_ready = 1'b0;
    send(32'hFFF00293, acc);
    i_valid = 1'b1;
    i_instr = 32'h002081B3;
    repeat (3) begin
      @(negedge i_clk);
      check("bp_ready", 64'(o_ready), 64'd0);
    end
    @(posedge i_clk); #1;
    i_ready = 1'b1;
    send(32'h002081B3, acc);
    check("drain_load_same_edge", 64'(acc), 64'(last_pop_cyc));
    drain_wait();

    // reset during a stall
    i_ready = 1'b0;
    send(32'h123450B7, acc);
    @(posedge i_clk); #2;
    i_rst_n = 1'b0;
    #1;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_cnt", 64'(o_illegal_cnt), 64'd0);
    sb_q.delete();
    model_cnt = 0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    send(32'h4033D313, acc);
    drain_wait();

    // randomized traffic with random backpressure and gaps
    rand_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      r = $urandom();
      case ($urandom_range(0, 3))
        0: opc = 7'h33;
        1: opc = 7'h13;
        2: opc = 7'h37;
        default: opc = 7'($urandom());
      endcase
      case ($urandom_range(0, 2))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        default: f7 = 7'($urandom());
      endcase
      w = {f7, r[24:7], opc};
      send(w, acc);
      repeat ($urandom_range(0, 2)) begin @(posedge i_clk); #1; end
    end
    rand_ready = 1'b0;
    @(posedge i_clk); #2;
    i_ready = 1'b1;
    drain_wait();

    // saturation
    for (int n = 0; n < 300; n++) begin
      w = (n % 2 == 0) ? 32'h00000000 : 32'hFFFFFFFF;
      send(w, acc);
    end
    drain_wait();
    check("cnt_saturated", 64'(o_illegal_cnt), 64'(CNT_SAT));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
